// File: rtl/wb_stage_pipe_reg.sv
// wb_stage_pipe_reg: MEM->WB pipeline register carrying NUM_CH independent write-back channels.
//
// Holds one slot (valid bit plus per-channel we/waddr/wdata) between the last execute/memory
// stage and the register-file write port. The slot is controlled by the core-wide stall vector:
//   s = stall[STAGE_IDX] (this stage), d = stall[STAGE_IDX+1] (downstream stage).
// Per rising edge, in priority order:
//   reset -> clear, flush -> bubble, s & ~d -> bubble, s & d -> hold, ~s -> advance.
// On advance, a channel write enable survives only for a valid slot and a nonzero address, so
// writes to $zero never leave this stage. Address and data are captured unchanged either way.
//
// Forwarding is combinational from the registered slot only. When several channels match,
// the highest channel index wins, matching the register-file write-port resolution.
//
// Optional feature (macro PERF_CNT_EN): three saturating CNT_W-bit counters for inserted
// bubbles, held cycles and accepted valid slots. They are cleared by reset only. With the
// macro undefined, the perf_* ports and the CNT_W parameter do not exist.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-high
//   stall        in   [STALL_W-1:0] stall vector from hazard controller
//   flush        in   squash stage contents
//   in_valid     in   upstream slot holds a real instruction
//   in_we        in   [NUM_CH-1:0] per-channel write enable
//   in_waddr     in   [NUM_CH*ADDR_W-1:0] per-channel address, ch0 in LSBs
//   in_wdata     in   [NUM_CH*DATA_W-1:0] per-channel data, ch0 in LSBs
//   out_valid    out  registered valid
//   out_we       out  [NUM_CH-1:0] registered write enables
//   out_waddr    out  [NUM_CH*ADDR_W-1:0] registered addresses
//   out_wdata    out  [NUM_CH*DATA_W-1:0] registered data
//   fwd_raddr    in   [ADDR_W-1:0] forwarding query address
//   fwd_hit      out  a held valid channel writes fwd_raddr (nonzero)
//   fwd_data     out  [DATA_W-1:0] data of the matching channel, 0 if no hit
//   perf_bubble  out  [CNT_W-1:0] bubbles inserted (PERF_CNT_EN only)
//   perf_hold    out  [CNT_W-1:0] cycles held (PERF_CNT_EN only)
//   perf_retire  out  [CNT_W-1:0] valid slots accepted (PERF_CNT_EN only)

module wb_stage_pipe_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STAGE_IDX = 4
`ifdef PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [NUM_CH-1:0]        in_we,
  input  logic [NUM_CH*ADDR_W-1:0] in_waddr,
  input  logic [NUM_CH*DATA_W-1:0] in_wdata,
  output logic                     out_valid,
  output logic [NUM_CH-1:0]        out_we,
  output logic [NUM_CH*ADDR_W-1:0] out_waddr,
  output logic [NUM_CH*DATA_W-1:0] out_wdata,
  input  logic [ADDR_W-1:0]        fwd_raddr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]         perf_bubble,
  output logic [CNT_W-1:0]         perf_hold,
  output logic [CNT_W-1:0]         perf_retire
`endif
);

  typedef enum logic [1:0] {
    ActAdvance,
    ActBubble,
    ActHold
  } act_e;

  logic                     stall_s;
  logic                     stall_d;
  act_e                     act;

  logic                     valid_q, valid_d;
  logic [NUM_CH-1:0]        we_q, we_d;
  logic [NUM_CH*ADDR_W-1:0] waddr_q, waddr_d;
  logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;

  // Only two bits of the shared stall vector belong to this stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign stall_s = stall[STAGE_IDX];
  assign stall_d = stall[STAGE_IDX+1];

  // Flush beats any stall state; d only matters while this stage is stalled.
  always_comb begin
    act = ActAdvance;
    if (flush) begin
      act = ActBubble;
    end else if (stall_s) begin
      act = stall_d ? ActHold : ActBubble;
    end
  end

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (act)
      ActBubble: begin
        valid_d = 1'b0;
        we_d    = '0;
        waddr_d = '0;
        wdata_d = '0;
      end
      ActHold: begin
        valid_d = valid_q;
      end
      default: begin
        valid_d = in_valid;
        waddr_d = in_waddr;
        wdata_d = in_wdata;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          we_d[i] = in_valid & in_we[i] & (in_waddr[i*ADDR_W +: ADDR_W] != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign out_valid = valid_q;
  assign out_we    = we_q;
  assign out_waddr = waddr_q;
  assign out_wdata = wdata_q;

  // Ascending scan so the highest matching channel overwrites lower ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (valid_q && we_q[i] && (waddr_q[i*ADDR_W +: ADDR_W] == fwd_raddr) &&
          (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  always_comb begin
    bubble_d = bubble_q;
    hold_d   = hold_q;
    retire_d = retire_q;
    if ((act == ActBubble) && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
    if ((act == ActHold) && (hold_q != '1)) begin
      hold_d = hold_q + CNT_W'(1);
    end
    if ((act == ActAdvance) && in_valid && (retire_q != '1)) begin
      retire_d = retire_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_q <= '0;
      hold_q   <= '0;
      retire_q <= '0;
    end else begin
      bubble_q <= bubble_d;
      hold_q   <= hold_d;
      retire_q <= retire_d;
    end
  end

  assign perf_bubble = bubble_q;
  assign perf_hold   = hold_q;
  assign perf_retire = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage_pipe_reg.sv
// Self-checking bench for wb_stage_pipe_reg: directed scenarios followed by randomized
// cycles, all checked against a slot-level behavioural model kept in this file.

module tb_wb_stage_pipe_reg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_CH    = 2;
  localparam int STALL_W   = 6;
  localparam int STAGE_IDX = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [STALL_W-1:0]       stall;
  logic                     flush;
  logic                     in_valid;
  logic [NUM_CH-1:0]        in_we;
  logic [NUM_CH*ADDR_W-1:0] in_waddr;
  logic [NUM_CH*DATA_W-1:0] in_wdata;
  logic                     out_valid;
  logic [NUM_CH-1:0]        out_we;
  logic [NUM_CH*ADDR_W-1:0] out_waddr;
  logic [NUM_CH*DATA_W-1:0] out_wdata;
  logic [ADDR_W-1:0]        fwd_raddr;
  logic                     fwd_hit;
  logic [DATA_W-1:0]        fwd_data;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0]         perf_bubble;
  logic [CNT_W-1:0]         perf_hold;
  logic [CNT_W-1:0]         perf_retire;
`endif

  always #5 clk = ~clk;

  wb_stage_pipe_reg #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_CH   (NUM_CH),
    .STALL_W  (STALL_W),
    .STAGE_IDX(STAGE_IDX)
`ifdef PERF_CNT_EN
    ,
    .CNT_W    (CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_we      (in_we),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .out_valid  (out_valid),
    .out_we     (out_we),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata),
    .fwd_raddr  (fwd_raddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`ifdef PERF_CNT_EN
    ,
    .perf_bubble(perf_bubble),
    .perf_hold  (perf_hold),
    .perf_retire(perf_retire)
`endif
  );

  // Reference slot: one entry per channel, plus event counts.
  bit                m_valid;
  bit                m_we    [NUM_CH];
  logic [ADDR_W-1:0] m_waddr [NUM_CH];
  logic [DATA_W-1:0] m_wdata [NUM_CH];
  int                m_bubble;
  int                m_hold;
  int                m_retire;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic model_clear_slot();
    m_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_we[i]    = 1'b0;
      m_waddr[i] = '0;
      m_wdata[i] = '0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock the DUT and compare everything.
  task automatic step(input bit rst, input bit fl, input bit s, input bit d, input bit iv,
                      input logic [NUM_CH-1:0] we, input logic [ADDR_W-1:0] a0,
                      input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] d1, input logic [ADDR_W-1:0] fq);
    logic [ADDR_W-1:0] ia [NUM_CH];
    logic [DATA_W-1:0] id [NUM_CH];
    bit                exp_hit;
    logic [DATA_W-1:0] exp_data;
    ia[0] = a0; ia[1] = a1;
    id[0] = d0; id[1] = d1;

    reset            = rst;
    flush            = fl;
    stall            = STALL_W'($urandom);
    stall[STAGE_IDX]   = s;
    stall[STAGE_IDX+1] = d;
    in_valid         = iv;
    in_we            = we;
    in_waddr         = {a1, a0};
    in_wdata         = {d1, d0};
    fwd_raddr        = fq;

    if (rst) begin
      model_clear_slot();
      m_bubble = 0;
      m_hold   = 0;
      m_retire = 0;
    end else if (fl || (s && !d)) begin
      model_clear_slot();
      m_bubble = sat_inc(m_bubble);
    end else if (s) begin
      m_hold = sat_inc(m_hold);
    end else begin
      m_valid = iv;
      for (int i = 0; i < NUM_CH; i++) begin
        m_we[i]    = iv && we[i] && (ia[i] != 0);
        m_waddr[i] = ia[i];
        m_wdata[i] = id[i];
      end
      if (iv) m_retire = sat_inc(m_retire);
    end

    @(posedge clk);
    #1;

    check("out_valid", out_valid, m_valid);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("out_we[%0d]", i), out_we[i], m_we[i]);
      check($sformatf("out_waddr[%0d]", i), out_waddr[i*ADDR_W +: ADDR_W], m_waddr[i]);
      check($sformatf("out_wdata[%0d]", i), out_wdata[i*DATA_W +: DATA_W], m_wdata[i]);
    end

    exp_hit  = 1'b0;
    exp_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!exp_hit && m_valid && m_we[i] && (m_waddr[i] == fq) && (fq != 0)) begin
        exp_hit  = 1'b1;
        exp_data = m_wdata[i];
      end
    end
    check("fwd_hit", fwd_hit, exp_hit);
    check("fwd_data", fwd_data, exp_data);
`ifdef PERF_CNT_EN
    check("perf_bubble", perf_bubble, m_bubble);
    check("perf_hold", perf_hold, m_hold);
    check("perf_retire", perf_retire, m_retire);
`endif
  endtask

  initial begin
    model_clear_slot();
    m_bubble = 0;
    m_hold   = 0;
    m_retire = 0;

    // T1: reset with nonzero inputs clears everything.
    step(1, 0, 0, 0, 1, 2'b11, 5'd7, 5'd9, 32'hDEAD, 32'hBEEF, 5'd7);
    step(1, 1, 1, 1, 1, 2'b11, 5'd7, 5'd9, 32'hDEAD, 32'hBEEF, 5'd9);
    check("T1 out_valid", out_valid, 1'b0);
    check("T1 fwd_hit", fwd_hit, 1'b0);

    // T2: advance both channels, forward from ch0.
    step(0, 0, 0, 0, 1, 2'b11, 5'd8, 5'd9, 32'hA, 32'hB, 5'd8);
    check("T2 out_we", out_we, 2'b11);
    check("T2 fwd_hit", fwd_hit, 1'b1);
    check("T2 fwd_data", fwd_data, 32'hA);

    // T3: hold three cycles with new inputs, then bubble.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 1, 2'b11, 5'd20, 5'd21, $urandom, $urandom, 5'd9);
    end
    check("T3 held wdata", out_wdata, {32'hB, 32'hA});
    step(0, 0, 1, 0, 1, 2'b11, 5'd20, 5'd21, 32'h5, 32'h6, 5'd9);
    check("T3 bubble valid", out_valid, 1'b0);
    check("T3 bubble wdata", out_wdata, 64'h0);

    // T4: write to $zero is suppressed; query of $zero never hits.
    step(0, 0, 0, 1, 1, 2'b01, 5'd0, 5'd4, 32'h77, 32'h88, 5'd0);
    check("T4 out_we", out_we, 2'b00);
    check("T4 out_valid", out_valid, 1'b1);

    // Invalid slot forces enables low.
    step(0, 0, 0, 0, 0, 2'b11, 5'd3, 5'd4, 32'h1, 32'h2, 5'd3);

    // T5: duplicate address, highest channel wins; flush overrides hold.
    step(0, 0, 0, 0, 1, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 5'd3);
    check("T5 fwd_data", fwd_data, 32'h22);
    step(0, 0, 1, 1, 1, 2'b11, 5'd5, 5'd6, 32'h33, 32'h44, 5'd3);
    step(0, 1, 1, 1, 1, 2'b11, 5'd5, 5'd6, 32'h33, 32'h44, 5'd3);
    check("T5 flush valid", out_valid, 1'b0);

    // Reset mid-hold discards held contents.
    step(0, 0, 0, 0, 1, 2'b11, 5'd12, 5'd13, 32'hC, 32'hD, 5'd12);
    step(0, 0, 1, 1, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12);
    step(1, 0, 1, 1, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd12);

`ifdef PERF_CNT_EN
    // T6: counters saturate at CNT_W all-ones.
    step(1, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 0, 1, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 5'd1);
    end
    check("T6 perf_bubble", perf_bubble, 2'd3);
    step(0, 0, 0, 0, 1, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 5'd1);
    step(0, 0, 0, 1, 1, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 5'd2);
    check("T6 perf_retire", perf_retire, 2'd2);
`endif

    // Randomized cycles with small address range to hit $zero and duplicates often.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
           1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom),
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), $urandom, $urandom,
           5'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
